// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Eight-entry general-purpose register file. It has one synchronous write
//   port and two combinational read ports that feed the ALU operands.
//
//   Parameters
//     DATA_WIDTH   register / data-port width in bits (default 8)
//     ADDR_WIDTH   register index width; register count is 2**ADDR_WIDTH
//
//   Ports
//     CLK          clock; all state changes happen on its rising edge
//     RESET        asynchronous, active-high; clears every register at once
//     IN           write data, normally the ALU RESULT
//     INADDRESS    write register index
//     WRITE        write enable
//     BUSYWAIT     stall; while high, writes are suppressed
//     OUT1ADDRESS  read port 1 register index
//     OUT2ADDRESS  read port 2 register index
//     OUT1         read port 1 data (ALU DATA1)
//     OUT2         read port 2 data (ALU DATA2 via the operand mux)
//
//   R0 is an ordinary register and is not tied to zero. Reads have no write
//   bypass. A read of the register being written shows the old value until
//   the writing edge.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// reg_file_chk
//   Simulation-only checker. It flags an enabled write whose index carries
//   X/Z bits. The datapath already drops such a write, because the per-entry
//   index compare never resolves true for an unknown index.
//
//   Ports
//     clk_i        clock
//     rst_i        reset; disables the check while high
//     wr_en_i      effective write enable (WRITE && !BUSYWAIT)
//     waddr_i      write register index
// ---------------------------------------------------------------------------
module reg_file_chk #(
  parameter int ADDR_WIDTH = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  wr_en_i,
  input logic [ADDR_WIDTH-1:0] waddr_i
);

  // An enabled write must present a fully known register index.
  a_waddr_known: assert property (
    @(posedge clk_i) disable iff (rst_i) wr_en_i |-> !$isunknown(waddr_i)
  );

endmodule

module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic                  BUSYWAIT,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] out1_s;
  logic [DATA_WIDTH-1:0] out2_s;

  // A stall always wins over a write request.
  assign wr_en_s = WRITE & ~BUSYWAIT;

  // Next-state: at most one entry takes IN; every other entry holds.
  // Each entry uses its own equality compare instead of an indexed store.
  // As a result, an X/Z index matches no entry, and the write is dropped
  // without touching any register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (INADDRESS == ADDR_WIDTH'(i)) begin
          regs_d[i] = IN;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array. RESET clears every entry immediately and blocks any
  // write that is enabled at a coincident edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read muxes. There is no write bypass, so both ports see
  // the stored contents only.
  always_comb begin
    out1_s = {DATA_WIDTH{1'b0}};
    out2_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (OUT1ADDRESS == ADDR_WIDTH'(i)) begin
        out1_s = regs_q[i];
      end else begin
        out1_s = out1_s;
      end
      if (OUT2ADDRESS == ADDR_WIDTH'(i)) begin
        out2_s = regs_q[i];
      end else begin
        out2_s = out2_s;
      end
    end
  end

  assign OUT1 = out1_s;
  assign OUT2 = out2_s;

  // Write-index sanity checker.
  reg_file_chk #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_chk (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .wr_en_i (wr_en_s),
    .waddr_i (INADDRESS)
  );

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file. Directed scenarios come first,
//   followed by randomized traffic. Expected values come from a plain array
//   model of the eight registers. The model is updated by the rule "an edge
//   with RESET=0, WRITE=1 and BUSYWAIT=0 stores IN at INADDRESS", and
//   asserting RESET clears the model.
// ---------------------------------------------------------------------------
module tb_reg_file;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] IN;
  logic [AW-1:0] INADDRESS;
  logic          WRITE;
  logic          BUSYWAIT;
  logic [AW-1:0] OUT1ADDRESS;
  logic [AW-1:0] OUT2ADDRESS;
  logic [DW-1:0] OUT1;
  logic [DW-1:0] OUT2;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] model [NR];
  logic [DW-1:0] alu_sum;

  reg_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .BUSYWAIT    (BUSYWAIT),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .OUT1        (OUT1),
    .OUT2        (OUT2)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    OUT1ADDRESS = a1;
    OUT2ADDRESS = a2;
    #1;
    check_eq({tag, "/out1"}, OUT1, model[a1]);
    check_eq({tag, "/out2"}, OUT2, model[a2]);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < NR; i++) begin
      read_check(tag, AW'(i), AW'(NR - 1 - i));
    end
  endtask

  task automatic write_edge(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    INADDRESS = a;
    IN        = d;
    WRITE     = 1'b1;
    BUSYWAIT  = 1'b0;
    @(posedge CLK);
    if (!RESET) model[a] = d;
    #1;
    WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; IN = 8'h00; INADDRESS = 3'd0; WRITE = 1'b0; BUSYWAIT = 1'b0;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    clear_model();
    #12;
    sweep("reset");
    @(negedge CLK);
    RESET = 1'b0;

    // Basic write/read, followed by an ALU add of the two operands.
    write_edge(3'd1, 8'd50);
    write_edge(3'd2, 8'd58);
    read_check("basic", 3'd1, 3'd2);
    check_eq("basic_out1", OUT1, 8'h32);
    check_eq("basic_out2", OUT2, 8'h3A);
    alu_sum = OUT1 + OUT2;
    check_eq("basic_add", alu_sum, 8'h6C);

    // Raw bit patterns, and R0 is writable.
    write_edge(3'd7, 8'hFF);
    write_edge(3'd0, 8'h01);
    read_check("signed", 3'd7, 3'd0);
    check_eq("signed_out1", OUT1, 8'hFF);
    check_eq("signed_out2", OUT2, 8'h01);
    alu_sum = OUT1 + OUT2;
    check_eq("signed_add", alu_sum, 8'h00);

    // Read-during-write: the old value shows before the edge, the new one after.
    write_edge(3'd3, 8'hAA);
    @(negedge CLK);
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h55; OUT1ADDRESS = 3'd3;
    #1;
    check_eq("rdw_before", OUT1, 8'hAA);
    @(posedge CLK);
    model[3] = 8'h55;
    #1;
    check_eq("rdw_after", OUT1, 8'h55);
    WRITE = 1'b0;

    // Stall holds R4 across three edges, then the write lands.
    @(negedge CLK);
    WRITE = 1'b1; BUSYWAIT = 1'b1; INADDRESS = 3'd4; IN = 8'h77;
    repeat (3) @(posedge CLK);
    #1;
    OUT1ADDRESS = 3'd4;
    #1;
    check_eq("stall_hold", OUT1, 8'h00);
    @(negedge CLK);
    BUSYWAIT = 1'b0;
    @(posedge CLK);
    model[4] = 8'h77;
    #1;
    check_eq("stall_release", OUT1, 8'h77);
    WRITE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      IN = 8'h11 * DW'(k + 1);
      INADDRESS = AW'(k);
    end
    @(posedge CLK);
    #1;
    sweep("write_disabled");

    // Asynchronous reset mid-cycle, a write blocked during reset, then recovery.
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    clear_model();
    sweep("async_reset");
    @(negedge CLK);
    WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h99;
    @(posedge CLK);
    #1;
    OUT1ADDRESS = 3'd6;
    #1;
    check_eq("reset_blocks_write", OUT1, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    model[6] = 8'h99;
    #1;
    check_eq("write_after_reset", OUT1, 8'h99);
    WRITE = 1'b0;

    // Same address on both read ports, and an aliasing sweep.
    write_edge(3'd5, 8'hC6);
    read_check("same_addr", 3'd5, 3'd5);
    check_eq("same_addr_out1", OUT1, 8'hC6);
    check_eq("same_addr_out2", OUT2, 8'hC6);
    for (int i = 0; i < NR; i++) write_edge(AW'(i), 8'hA0 + DW'(i * 3));
    sweep("alias");

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      WRITE       = ($urandom_range(0, 3) != 0);
      BUSYWAIT    = ($urandom_range(0, 3) == 0);
      INADDRESS   = AW'($urandom);
      IN          = DW'($urandom);
      OUT1ADDRESS = AW'($urandom);
      OUT2ADDRESS = ($urandom_range(0, 4) == 0) ? INADDRESS : AW'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        RESET = 1'b1;
        clear_model();
      end else begin
        RESET = 1'b0;
      end
      #1;
      check_eq("rand_pre_out1", OUT1, model[OUT1ADDRESS]);
      check_eq("rand_pre_out2", OUT2, model[OUT2ADDRESS]);
      @(posedge CLK);
      if (!RESET && WRITE && !BUSYWAIT) model[INADDRESS] = IN;
      #1;
      check_eq("rand_post_out1", OUT1, model[OUT1ADDRESS]);
      check_eq("rand_post_out2", OUT2, model[OUT2ADDRESS]);
    end
    @(negedge CLK);
    RESET = 1'b0; WRITE = 1'b0;
    #1;
    sweep("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, giving the address width; register count is 2**ADDR_WIDTH (8).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port IN, input, DATA_WIDTH bits: write data, normally the ALU RESULT.
REQ-006 The block SHALL have port INADDRESS, input, ADDR_WIDTH bits: write register index.
REQ-007 The block SHALL have port WRITE, input, 1 bit: write enable.
REQ-008 The block SHALL have port BUSYWAIT, input, 1 bit: stall; when high, it suppresses writes.
REQ-009 The block SHALL have port OUT1ADDRESS, input, ADDR_WIDTH bits: read port 1 register index.
REQ-010 The block SHALL have port OUT2ADDRESS, input, ADDR_WIDTH bits: read port 2 register index.
REQ-011 The block SHALL have port OUT1, output, DATA_WIDTH bits: read port 1 data, feeding ALU DATA1.
REQ-012 The block SHALL have port OUT2, output, DATA_WIDTH bits: read port 2 data, feeding ALU DATA2 (via the operand mux).

Function
REQ-013 The block SHALL hold 8 registers R0..R7 of DATA_WIDTH bits each; R0 SHALL be an ordinary writable register (it is not hard-wired to zero).
REQ-014 The write port SHALL load IN into R[INADDRESS] on a CLK rising edge only when WRITE=1, BUSYWAIT=0 and RESET=0, sampling all three at that edge.
REQ-015 When WRITE=0 or BUSYWAIT=1 at an edge, all registers SHALL hold their values.
REQ-016 Write latency SHALL be one edge: the new value is visible on any read port addressing it immediately after the writing edge.
REQ-017 Reads SHALL be combinational and asynchronous to CLK: OUT1 = R[OUT1ADDRESS] and OUT2 = R[OUT2ADDRESS], updating whenever an address or the addressed register changes.
REQ-018 Read-during-write SHALL have no bypass: before the writing edge, a read port addressing INADDRESS shows the old value; after the edge, it shows the new value.
REQ-019 Both read ports MAY address the same register and SHALL then both present its value.
REQ-020 Either read port MAY equal INADDRESS in the same cycle, and the write SHALL still occur.
REQ-021 Only one register SHALL change per edge; all non-addressed registers are unaffected.
REQ-022 Ports SHALL carry no arithmetic or sign handling; values are raw bit patterns, so 8'hFF is stored and returned as 8'hFF.
REQ-023 X or Z on INADDRESS with an enabled write SHALL NOT corrupt any register; the write SHALL be dropped (covered by an assertion in simulation).

Reset
REQ-024 RESET=1 SHALL clear R0..R7 to 0 immediately, without waiting for a CLK edge.
REQ-025 During reset, OUT1 and OUT2 SHALL read 0 for any address.
REQ-026 While RESET=1, writes SHALL be blocked, including a write enabled at an edge coincident with RESET assertion.
REQ-027 Reset asserted mid-operation (between a write setup and its edge) SHALL discard the pending write.
REQ-028 The first write after RESET deasserts SHALL take effect on the first rising edge at which RESET=0 and the write conditions of REQ-014 hold.

Verification
REQ-029 The bench SHALL cover basic write/read: RESET pulse; write R1=8'd50, then R2=8'd58 on consecutive edges; set OUT1ADDRESS=1, OUT2ADDRESS=2 -> OUT1=8'h32, OUT2=8'h3A; ALU with SELECT=3'b001 -> RESULT=8'h6C.
REQ-030 The bench SHALL cover the signed pattern: write R7=8'hFF, R0=8'h01; read OUT1ADDRESS=7, OUT2ADDRESS=0 -> OUT1=8'hFF, OUT2=8'h01; ALU add -> 8'h00.
REQ-031 The bench SHALL cover read-during-write: R3=8'hAA; then WRITE=1, INADDRESS=3, IN=8'h55, OUT1ADDRESS=3 -> OUT1=8'hAA before the edge and 8'h55 after it.
REQ-032 The bench SHALL cover stall and disable: WRITE=1, BUSYWAIT=1, INADDRESS=4, IN=8'h77 over 3 edges -> R4 unchanged (0); then drop BUSYWAIT -> R4=8'h77 after the next edge; WRITE=0 with IN changing -> no register changes.
REQ-033 The bench SHALL cover asynchronous reset: with registers loaded, assert RESET mid-cycle -> OUT1 and OUT2 go to 0 before the next edge; a write enabled at the edge while RESET=1 is dropped; deassert RESET -> writes resume.
REQ-034 The bench SHALL cover the same-address read: OUT1ADDRESS=OUT2ADDRESS=5 with R5=8'hC6 -> both outputs read 8'hC6; sweep all 8 addresses to confirm no aliasing.
